// File: rtl/mode_sequencer.sv
// Mode controller: turns button, switch and clap inputs into a one-hot display
// mode, runs the display counter and drives request/acknowledge LRU transactions.
module mode_sequencer #(
    parameter int unsigned CNT_DIV     = 100_000_000,
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned CLAP_HOLD   = 50_000_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        btn_mode_i,
    input  logic        btn_go_i,
    input  logic        clap_i,
    input  logic [15:0] sw_i,
    input  logic        lru_ack_i,
    input  logic [31:0] lru_rdata_i,
    output logic [2:0]  state_o,
    output logic [1:0]  clap_state_o,
    output logic        cnt_en_o,
    output logic        lru_req_o,
    output logic        lru_we_o,
    output logic [15:0] lru_wdata_o,
    output logic [31:0] data_o,
    output logic        busy_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        ModeIdle = 3'b000,
        ModeCnt  = 3'b100,
        ModeWr   = 3'b010,
        ModeRd   = 3'b001
    } mode_t;

    typedef enum logic {
        TxIdle = 1'b0,
        TxWait = 1'b1
    } tx_t;

    localparam logic [31:0] PrescLast   = 32'(CNT_DIV - 1);
    localparam logic [15:0] TimeoutLast = 16'(ACK_TIMEOUT - 1);
    localparam logic [31:0] HoldLoad    = 32'(CLAP_HOLD);

    mode_t       mode, mode_next;
    tx_t         tx, tx_next;
    logic        pause, pause_next;
    logic        cnt_en, cnt_en_next;
    logic [31:0] presc, presc_next;
    logic [31:0] count, count_next;
    logic [31:0] hold, hold_next;
    logic        clap_ind, clap_ind_next;
    logic [15:0] timer, timer_next;
    logic        we, we_next;
    logic [15:0] wdata, wdata_next;
    logic [31:0] rdata, rdata_next;
    logic        err, err_next;

    logic mode_s1, mode_s2, mode_s3;
    logic go_s1, go_s2, go_s3;
    logic mode_edge, go_edge, busy, mode_adv, go_accept;

    // Two-flop synchronizers plus one delay stage for rising-edge detection
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mode_s1 <= 1'b0;
            mode_s2 <= 1'b0;
            mode_s3 <= 1'b0;
            go_s1   <= 1'b0;
            go_s2   <= 1'b0;
            go_s3   <= 1'b0;
        end else begin
            mode_s1 <= btn_mode_i;
            mode_s2 <= mode_s1;
            mode_s3 <= mode_s2;
            go_s1   <= btn_go_i;
            go_s2   <= go_s1;
            go_s3   <= go_s2;
        end
    end

    assign mode_edge = mode_s2 & ~mode_s3;
    assign go_edge   = go_s2 & ~go_s3;
    assign busy      = (tx == TxWait);
    assign mode_adv  = mode_edge & ~busy;
    // A simultaneous mode edge wins, so the go edge is dropped
    assign go_accept = go_edge & ~mode_edge & ~busy & ((mode == ModeWr) || (mode == ModeRd));

    // Next-state logic for mode, counter, clap indicator and transaction FSM
    always_comb begin
        mode_next  = mode;
        tx_next    = tx;
        pause_next = pause;
        presc_next = presc;
        count_next = count;
        hold_next  = hold;
        timer_next = timer;
        we_next    = we;
        wdata_next = wdata;
        rdata_next = rdata;
        err_next   = err;

        if (cnt_en) begin
            if (presc == PrescLast) begin
                presc_next = '0;
                count_next = count + 32'd1;
            end else begin
                presc_next = presc + 32'd1;
            end
        end

        if (clap_i) begin
            hold_next = HoldLoad;
            if (mode == ModeCnt) begin
                pause_next = ~pause;
            end
        end else if (hold != '0) begin
            hold_next = hold - 32'd1;
        end

        case (tx)
            TxIdle: begin
                if (go_accept) begin
                    tx_next    = TxWait;
                    timer_next = '0;
                    wdata_next = sw_i;
                    we_next    = (mode == ModeWr);
                    err_next   = 1'b0;
                end
            end
            TxWait: begin
                // Ack takes priority over an expiry in the same cycle
                if (lru_ack_i) begin
                    tx_next = TxIdle;
                    if (!we) begin
                        rdata_next = lru_rdata_i;
                    end
                end else if (timer == TimeoutLast) begin
                    tx_next  = TxIdle;
                    err_next = 1'b1;
                end else begin
                    timer_next = timer + 16'd1;
                end
            end
            default: tx_next = TxIdle;
        endcase

        if (mode_adv) begin
            err_next = 1'b0;
            unique case (mode)
                ModeIdle: begin
                    mode_next  = ModeCnt;
                    pause_next = 1'b0;
                end
                ModeCnt: mode_next = ModeWr;
                ModeWr:  mode_next = ModeRd;
                default: mode_next = ModeIdle;
            endcase
        end

        cnt_en_next   = (mode_next == ModeCnt) && !pause_next;
        clap_ind_next = (hold_next != '0);
        // Pausing or leaving counting mode discards the partial prescale
        if (!cnt_en_next) begin
            presc_next = '0;
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mode     <= ModeIdle;
            tx       <= TxIdle;
            pause    <= 1'b0;
            cnt_en   <= 1'b0;
            presc    <= '0;
            count    <= '0;
            hold     <= '0;
            clap_ind <= 1'b0;
            timer    <= '0;
            we       <= 1'b0;
            wdata    <= '0;
            rdata    <= '0;
            err      <= 1'b0;
        end else begin
            mode     <= mode_next;
            tx       <= tx_next;
            pause    <= pause_next;
            cnt_en   <= cnt_en_next;
            presc    <= presc_next;
            count    <= count_next;
            hold     <= hold_next;
            clap_ind <= clap_ind_next;
            timer    <= timer_next;
            we       <= we_next;
            wdata    <= wdata_next;
            rdata    <= rdata_next;
            err      <= err_next;
        end
    end

    // Display value selected by the current mode
    always_comb begin
        data_o = '0;
        unique case (mode)
            ModeCnt: data_o = count;
            ModeWr:  data_o = {16'h0000, wdata};
            ModeRd:  data_o = rdata;
            default: data_o = '0;
        endcase
    end

    assign state_o      = mode;
    assign clap_state_o = {pause, clap_ind};
    assign cnt_en_o     = cnt_en;
    assign lru_req_o    = busy;
    assign busy_o       = busy;
    assign lru_we_o     = we;
    assign lru_wdata_o  = wdata;
    assign err_o        = err;

endmodule
